palette_lut_banked: RTL and testbench

- Runtime-writable, multi-bank colour palette for the sprite/background pixel path. Replaces fixed per-asset palette ROMs.
- Maps a pixel colour index to RGB through a 2-stage pipeline. Adds per-frame bank switching, a transparency key and a global brightness fade.
- Sits between the sprite/background index fetch and the VGA colour mux.

---
 rtl/palette_lut_banked.sv | 144 ++++++++++++++
 tb/tb_palette_lut_banked.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_lut_banked.sv
// Purpose: runtime-writable multi-bank colour palette mapping pixel index to faded RGB.
// Latency: fixed 2 cycles from pix_valid_i to out_valid_o, one pixel per cycle.
// Backpressure: none; the pipeline never stalls and the consumer must accept every pixel.
module palette_lut_banked #(
  parameter int INDEX_W      = 4,
  parameter int CH_W         = 4,
  parameter int NUM_BANKS    = 2,
  parameter int TRANSP_INDEX = 3,
  localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  frame_start_i,
  input  logic [BANK_W-1:0]     bank_req_i,
  input  logic [3:0]            fade_req_i,
  input  logic                  transp_en_i,
  input  logic                  wr_en_i,
  input  logic [BANK_W-1:0]     wr_bank_i,
  input  logic [INDEX_W-1:0]    wr_index_i,
  input  logic [3*CH_W-1:0]     wr_rgb_i,
  input  logic                  pix_valid_i,
  input  logic [INDEX_W-1:0]    pix_index_i,
  output logic                  out_valid_o,
  output logic                  out_transp_o,
  output logic [CH_W-1:0]       red_o,
  output logic [CH_W-1:0]       green_o,
  output logic [CH_W-1:0]       blue_o,
  output logic [BANK_W-1:0]     active_bank_o
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int RGB_W   = 3 * CH_W;
  localparam logic [BANK_W:0]    BANK_LIM = NUM_BANKS[BANK_W:0];
  localparam logic [INDEX_W-1:0] TIDX     = TRANSP_INDEX[INDEX_W-1:0];

  // Channel brightness scaling: c*(fade+1)/16, exact in CH_W+4 bits.
  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c, input logic [3:0] f);
    logic [CH_W+3:0] prod;
    prod = {4'b0000, c} * ({{CH_W{1'b0}}, f} + {{(CH_W+3){1'b0}}, 1'b1});
    return prod[CH_W+3:4];
  endfunction

  logic [RGB_W-1:0]  pal_q [NUM_BANKS][ENTRIES];
  logic [BANK_W-1:0] active_bank_q;
  logic [3:0]        active_fade_q;

  logic              v1_q;
  logic              t1_q;
  logic [RGB_W-1:0]  rgb1_q;
  logic [3:0]        fade1_q;

  logic              out_valid_q, out_transp_q;
  logic [CH_W-1:0]   red_q, green_q, blue_q;
  logic              out_transp_d;
  logic [CH_W-1:0]   red_d, green_d, blue_d;

  logic              wr_ok;
  logic              bank_ok;
  logic [RGB_W-1:0]  rd_rgb;

  assign wr_ok   = wr_en_i && ({1'b0, wr_bank_i} < BANK_LIM);
  assign bank_ok = {1'b0, bank_req_i} < BANK_LIM;
  // Read uses the pre-edge array contents, so a same-edge write is not bypassed.
  assign rd_rgb  = pal_q[active_bank_q][pix_index_i];

  // Palette storage: cleared on reset, written on any edge with a valid bank.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          pal_q[b][e] <= '0;
        end
      end
    end else if (wr_ok) begin
      pal_q[wr_bank_i][wr_index_i] <= wr_rgb_i;
    end
  end

  // Shadow bank/fade registers only change at frame start, never mid-frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      active_bank_q <= '0;
      active_fade_q <= 4'hF;
    end else if (frame_start_i) begin
      if (bank_ok) begin
        active_bank_q <= bank_req_i;
      end
      active_fade_q <= fade_req_i;
    end
  end

  // Stage 1: lookup, transparency key and fade capture (pre-update fade value).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1_q    <= 1'b0;
      t1_q    <= 1'b0;
      rgb1_q  <= '0;
      fade1_q <= 4'hF;
    end else begin
      v1_q    <= pix_valid_i;
      t1_q    <= transp_en_i && (pix_index_i == TIDX);
      rgb1_q  <= rd_rgb;
      fade1_q <= active_fade_q;
    end
  end

  // Stage 2 next-state: scaled colour, forced to zero when transparent or idle.
  always_comb begin
    out_transp_d = v1_q && t1_q;
    red_d        = '0;
    green_d      = '0;
    blue_d       = '0;
    if (v1_q && !t1_q) begin
      red_d   = scale(rgb1_q[3*CH_W-1:2*CH_W], fade1_q);
      green_d = scale(rgb1_q[2*CH_W-1:CH_W], fade1_q);
      blue_d  = scale(rgb1_q[CH_W-1:0], fade1_q);
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q  <= 1'b0;
      out_transp_q <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
    end else begin
      out_valid_q  <= v1_q;
      out_transp_q <= out_transp_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_transp_o  = out_transp_q;
  assign red_o         = red_q;
  assign green_o       = green_q;
  assign blue_o        = blue_q;
  assign active_bank_o = active_bank_q;

endmodule

// File: tb/tb_palette_lut_banked.sv
// Purpose: self-checking bench for palette_lut_banked against a behavioural palette model.
// Latency: model predicts each output two edges after its pixel is presented.
// Backpressure: none; every cycle's outputs are compared.
module tb_palette_lut_banked;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [0:0]  bank_req;
  logic [3:0]  fade_req;
  logic        transp_en;
  logic        wr_en;
  logic [0:0]  wr_bank;
  logic [3:0]  wr_index;
  logic [11:0] wr_rgb;
  logic        pix_valid;
  logic [3:0]  pix_index;
  logic        out_valid;
  logic        out_transp;
  logic [3:0]  red, green, blue;
  logic [0:0]  active_bank;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  palette_lut_banked dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .frame_start_i (frame_start),
    .bank_req_i    (bank_req),
    .fade_req_i    (fade_req),
    .transp_en_i   (transp_en),
    .wr_en_i       (wr_en),
    .wr_bank_i     (wr_bank),
    .wr_index_i    (wr_index),
    .wr_rgb_i      (wr_rgb),
    .pix_valid_i   (pix_valid),
    .pix_index_i   (pix_index),
    .out_valid_o   (out_valid),
    .out_transp_o  (out_transp),
    .red_o         (red),
    .green_o       (green),
    .blue_o        (blue),
    .active_bank_o (active_bank)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int pal_m [2][16];
  int bank_m, fade_m;
  int pend_vld, pend_tr, pend_rgb;
  int exp_vld, exp_tr, exp_rgb;

  function automatic int fade_ch(input int c, input int f);
    return (c * (f + 1)) / 16;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int e = 0; e < 16; e++) pal_m[b][e] = 0;
    bank_m = 0; fade_m = 15;
    pend_vld = 0; pend_tr = 0; pend_rgb = 0;
    exp_vld = 0; exp_tr = 0; exp_rgb = 0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_clear();
      end else begin
        int e;
        exp_vld = pend_vld; exp_tr = pend_tr; exp_rgb = pend_rgb;
        pend_vld = int'(pix_valid);
        pend_tr  = (pix_valid && transp_en && pix_index == 4'd3) ? 1 : 0;
        e = pal_m[bank_m][int'(pix_index)];
        if (!pix_valid || pend_tr != 0) pend_rgb = 0;
        else pend_rgb = (fade_ch((e >> 8) & 15, fade_m) << 8) |
                        (fade_ch((e >> 4) & 15, fade_m) << 4) |
                         fade_ch(e & 15, fade_m);
        if (wr_en) pal_m[int'(wr_bank)][int'(wr_index)] = int'(wr_rgb);
        if (frame_start) begin
          bank_m = int'(bank_req);
          fade_m = int'(fade_req);
        end
      end
    end
  end

  // Every-cycle comparison of DUT against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid",   32'(out_valid),            32'(exp_vld));
      chk("out_transp",  32'(out_transp),           32'(exp_tr));
      chk("rgb",         32'({red, green, blue}),   32'(exp_rgb));
      chk("active_bank", 32'(active_bank),          32'(bank_m));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    frame_start = 1'b0; transp_en = 1'b0; wr_en = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic wr(input logic b, input logic [3:0] i, input logic [11:0] d);
    wr_en = 1'b1; wr_bank = b; wr_index = i; wr_rgb = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic frame(input logic b, input logic [3:0] f);
    frame_start = 1'b1; bank_req = b; fade_req = f;
    tick();
    frame_start = 1'b0;
  endtask

  // Presents one pixel and returns after the edge on which it reaches the output.
  task automatic rd(input logic [3:0] i, input logic te);
    pix_valid = 1'b1; pix_index = i; transp_en = te;
    tick();
    pix_valid = 1'b0; transp_en = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; bank_req = '0; fade_req = 4'hF; wr_bank = '0; wr_index = '0;
    wr_rgb = '0; pix_index = '0;
    idle();
    repeat (3) tick();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset rgb", 32'({red, green, blue}), 32'h000);
    chk("reset bank", 32'(active_bank), 32'd0);
    rst_n = 1'b1;
    tick();

    // First pixel after reset: exact 2-cycle latency, palette cleared.
    pix_valid = 1'b1; pix_index = 4'd5;
    tick();
    pix_valid = 1'b0;
    chk("lat1 out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat2 out_valid", 32'(out_valid), 32'd1);
    chk("first rgb", 32'({red, green, blue}), 32'h000);
    chk("first transp", 32'(out_transp), 32'd0);

    // Bank switching only at frame start.
    wr(1'b0, 4'd5, 12'h863);
    wr(1'b1, 4'd5, 12'hCCA);
    rd(4'd5, 1'b0);
    chk("bank0 read", 32'({red, green, blue}), 32'h863);
    bank_req = 1'b1;
    rd(4'd5, 1'b0);
    chk("no frame_start", 32'({red, green, blue}), 32'h863);
    frame(1'b1, 4'hF);
    rd(4'd5, 1'b0);
    chk("bank1 read", 32'({red, green, blue}), 32'hCCA);
    chk("bank1 active", 32'(active_bank), 32'd1);
    frame(1'b0, 4'hF);

    // Read-before-write on the same edge.
    wr(1'b0, 4'd2, 12'h332);
    wr_en = 1'b1; wr_bank = 1'b0; wr_index = 4'd2; wr_rgb = 12'hFFF;
    rd(4'd2, 1'b0);
    wr_en = 1'b0;
    chk("rbw old", 32'({red, green, blue}), 32'h332);
    rd(4'd2, 1'b0);
    chk("rbw new", 32'({red, green, blue}), 32'hFFF);

    // Transparency key.
    wr(1'b0, 4'd3, 12'h842);
    rd(4'd3, 1'b1);
    chk("transp flag", 32'(out_transp), 32'd1);
    chk("transp rgb", 32'({red, green, blue}), 32'h000);
    rd(4'd3, 1'b0);
    chk("opaque flag", 32'(out_transp), 32'd0);
    chk("opaque rgb", 32'({red, green, blue}), 32'h842);

    // Brightness fade.
    wr(1'b0, 4'd7, 12'hE8C);
    frame(1'b0, 4'd7);
    rd(4'd7, 1'b0);
    chk("fade7", 32'({red, green, blue}), 32'h746);
    frame(1'b0, 4'd0);
    rd(4'd7, 1'b0);
    chk("fade0", 32'({red, green, blue}), 32'h000);
    frame(1'b0, 4'hF);
    rd(4'd7, 1'b0);
    chk("fade15", 32'({red, green, blue}), 32'hE8C);

    // Randomized traffic, including same-edge writes, frame starts and fades.
    for (int n = 0; n < 600; n++) begin
      frame_start = ($urandom_range(0, 15) == 0);
      bank_req    = 1'($urandom_range(0, 1));
      fade_req    = 4'($urandom_range(0, 15));
      transp_en   = 1'($urandom_range(0, 1));
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_bank     = 1'($urandom_range(0, 1));
      wr_index    = 4'($urandom_range(0, 7));
      wr_rgb      = 12'($urandom_range(0, 4095));
      pix_valid   = ($urandom_range(0, 3) != 0);
      pix_index   = 4'($urandom_range(0, 7));
      tick();
    end
    idle();
    frame(1'b0, 4'hF);

    // Stream indices, then reset mid-stream: outputs clear immediately.
    for (int i = 0; i < 5; i++) begin
      pix_valid = 1'b1; pix_index = 4'(i);
      tick();
    end
    chk("stream valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst rgb", 32'({red, green, blue}), 32'h000);
    chk("rst transp", 32'(out_transp), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post-rst idle", 32'(out_valid), 32'd0);
    pix_valid = 1'b1; pix_index = 4'd6;
    tick();
    pix_valid = 1'b0;
    chk("post-rst lat1", 32'(out_valid), 32'd0);
    tick();
    chk("post-rst lat2", 32'(out_valid), 32'd1);
    chk("post-rst rgb", 32'({red, green, blue}), 32'h000);
    tick();
    chk("post-rst drain", 32'(out_valid), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
